// File: rtl/pipelined_mac.sv
// Two-stage pipelined multiply-accumulate producing one dot product every N_TERMS accepted terms.
// Optional macro PIPELINED_MAC_SATURATE_EN clamps the result into y instead of wrapping.
module pipelined_mac #(
    parameter int WIDTH_X = 10,
    parameter int WIDTH_A = 4,
    parameter int N_TERMS = 8,
    parameter int WIDTH_Y = 18
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic signed [WIDTH_X-1:0] x,
    input  logic signed [WIDTH_A-1:0] a,
    output logic signed [WIDTH_Y-1:0] y,
    output logic                      out_valid,
    output logic                      sat,
    output logic                      busy
);

    localparam int PW = WIDTH_X + WIDTH_A;
    localparam int CW = $clog2(N_TERMS);
    localparam int AW = PW + $clog2(N_TERMS);

`ifdef PIPELINED_MAC_SATURATE_EN
    localparam int EW = (AW > WIDTH_Y) ? AW : WIDTH_Y;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-WIDTH_Y+1){1'b0}}, {(WIDTH_Y-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-WIDTH_Y+1){1'b1}}, {(WIDTH_Y-1){1'b0}}};
    logic signed [EW-1:0] sum_ext_s;
`endif

    logic                      accept_s;
    logic signed [PW-1:0]      prod_s;
    logic signed [AW-1:0]      sum_s;
    logic signed [WIDTH_Y-1:0] res_s;
    logic                      clamp_s;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic signed [PW-1:0]      p_q, p_d;
    logic                      p_valid_q, p_valid_d;
    logic                      p_first_q, p_first_d;
    logic                      p_last_q, p_last_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    logic signed [WIDTH_Y-1:0] y_q, y_d;
    logic                      out_valid_q, out_valid_d;
    logic                      sat_q, sat_d;
    logic                      busy_q, busy_d;

    // Datapath: product, running sum and the (optionally clamped) result value.
    always_comb begin
        accept_s = en & in_valid & ~clear;
        prod_s   = PW'(x) * PW'(a);
        // The first product of a vector restarts the sum so vectors never bleed into each other.
        sum_s    = (p_first_q ? {AW{1'b0}} : acc_q) + AW'(p_q);
`ifdef PIPELINED_MAC_SATURATE_EN
        sum_ext_s = EW'(sum_s);
        if (sum_ext_s > SAT_MAX) begin
            res_s   = WIDTH_Y'(SAT_MAX);
            clamp_s = 1'b1;
        end else if (sum_ext_s < SAT_MIN) begin
            res_s   = WIDTH_Y'(SAT_MIN);
            clamp_s = 1'b1;
        end else begin
            res_s   = WIDTH_Y'(sum_ext_s);
            clamp_s = 1'b0;
        end
`else
        res_s   = WIDTH_Y'(sum_s);
        clamp_s = 1'b0;
`endif
    end

    // Next-state logic: clear beats enable, and a low enable freezes everything.
    always_comb begin
        cnt_d       = cnt_q;
        p_d         = p_q;
        p_valid_d   = p_valid_q;
        p_first_d   = p_first_q;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        busy_d      = busy_q;
        if (clear) begin
            cnt_d     = {CW{1'b0}};
            p_d       = {PW{1'b0}};
            p_valid_d = 1'b0;
            p_first_d = 1'b0;
            p_last_d  = 1'b0;
            acc_d     = {AW{1'b0}};
            busy_d    = 1'b0;
        end else if (en) begin
            p_valid_d = accept_s;
            p_first_d = accept_s & (cnt_q == {CW{1'b0}});
            p_last_d  = accept_s & (cnt_q == CW'(N_TERMS - 1));
            if (accept_s) begin
                p_d = prod_s;
                if (cnt_q == CW'(N_TERMS - 1)) begin
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                p_d   = p_q;
                cnt_d = cnt_q;
            end
            if (p_valid_q) begin
                acc_d = sum_s;
                if (p_last_q) begin
                    y_d         = res_s;
                    sat_d       = clamp_s;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else begin
                acc_d = acc_q;
            end
            // Busy covers the partial vector plus the cycle its final product is still in flight.
            busy_d = (cnt_d != {CW{1'b0}}) | p_valid_d;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= {CW{1'b0}};
            p_q         <= {PW{1'b0}};
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= {AW{1'b0}};
            y_q         <= {WIDTH_Y{1'b0}};
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;
    assign busy      = busy_q;

endmodule
